// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
// Holds the FSM state encoding, the hard-wired zero register index,
// the pipeline-control payload struct and its canned output patterns.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Wide enough for any MEM_TIMEOUT in 1..255
    localparam int unsigned TMR_W = 8;

    // Enable and bubble controls for the PC and the four pipeline registers
    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic if_id_flush;
        logic id_ex_en;
        logic id_ex_bubble;
        logic ex_mem_en;
        logic mem_wb_en;
        logic mem_wb_bubble;
    } pipe_ctrl_t;

    // NOP control field: everything frozen and every stage loading a bubble
    localparam pipe_ctrl_t CTRL_NOP = '{
        pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b1, id_ex_en: 1'b0,
        id_ex_bubble: 1'b1, ex_mem_en: 1'b0, mem_wb_en: 1'b0, mem_wb_bubble: 1'b1};

    localparam pipe_ctrl_t CTRL_RUN = '{
        pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b0, id_ex_en: 1'b1,
        id_ex_bubble: 1'b0, ex_mem_en: 1'b1, mem_wb_en: 1'b1, mem_wb_bubble: 1'b0};

    localparam pipe_ctrl_t CTRL_MEM_STALL = '{
        pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b0, id_ex_en: 1'b0,
        id_ex_bubble: 1'b0, ex_mem_en: 1'b0, mem_wb_en: 1'b0, mem_wb_bubble: 1'b1};

    localparam pipe_ctrl_t CTRL_BRANCH = '{
        pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b1, id_ex_en: 1'b1,
        id_ex_bubble: 1'b1, ex_mem_en: 1'b1, mem_wb_en: 1'b1, mem_wb_bubble: 1'b0};

    localparam pipe_ctrl_t CTRL_LOAD_USE = '{
        pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b0, id_ex_en: 1'b1,
        id_ex_bubble: 1'b1, ex_mem_en: 1'b1, mem_wb_en: 1'b1, mem_wb_bubble: 1'b0};

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive MEM_WAIT cycles and flags the last allowed one.
// Ports: clk, rst_n; clear (entering MEM_WAIT), inc (in MEM_WAIT);
//        expire (combinational, timer has reached MEM_TIMEOUT-1).
module mem_wait_timer
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic inc,
    output logic expire
);

    if (MEM_TIMEOUT < 1 || MEM_TIMEOUT > 255) begin : g_bad_timeout
        $error("MEM_TIMEOUT must be in 1..255");
    end

    logic [TMR_W-1:0] timer_q;
    logic [TMR_W-1:0] timer_d;

    // Next timer value
    always_comb begin
        timer_d = timer_q;
        if (clear) begin
            timer_d = '0;
        end else if (inc) begin
            timer_d = timer_q + TMR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

    assign expire = (timer_q == TMR_W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage MIPS pipeline: memory waits,
// load-use stalls, taken-branch flushes and data-memory timeout detection.
// Inputs: id_rs/id_rt/id_uses_rt (ID), ex_mem_read/ex_write_reg/branch_taken
//         (EX), mem_req/mem_ready (MEM).
// Outputs: PC and pipeline-register enables, flush/bubble controls
//          (combinational), mem_err (registered, sticky).
// Optional: define STALL_PERF_CNT_EN to add the stall_cycles and
//           flush_count saturating performance counters.
module pipe_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_write_reg,
    input  logic       mem_req,
    input  logic       mem_ready,
    input  logic       branch_taken,
    output logic       pc_en,
    output logic       if_id_en,
    output logic       if_id_flush,
    output logic       id_ex_en,
    output logic       id_ex_bubble,
    output logic       ex_mem_en,
    output logic       mem_wb_en,
    output logic       mem_wb_bubble,
    output logic       mem_err
`ifdef STALL_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
`endif
);

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

    state_e     state_q;
    state_e     state_d;
    logic       mem_err_q;
    logic       mem_err_d;
    logic       mem_stall;
    logic       load_use;
    logic       expire;
    logic       tmr_clear;
    logic       tmr_inc;
    pipe_ctrl_t ctrl;

    // $0 is hard-wired, so a load targeting it never creates a dependency
    assign load_use = ex_mem_read && (ex_write_reg != REG_ZERO) &&
                      ((ex_write_reg == id_rs) ||
                       (id_uses_rt && (ex_write_reg == id_rt)));

    // Next state and control priority: memory stall > branch > load-use
    always_comb begin
        state_d   = state_q;
        mem_stall = 1'b0;
        ctrl      = CTRL_RUN;
        case (state_q)
            RUN: begin
                if (mem_req && !mem_ready) begin
                    state_d   = MEM_WAIT;
                    mem_stall = 1'b1;
                end
            end
            MEM_WAIT: begin
                // mem_ready beats a same-cycle expiry
                if (mem_ready) begin
                    state_d = RUN;
                end else begin
                    mem_stall = 1'b1;
                    if (expire) begin
                        state_d = ERR;
                    end
                end
            end
            ERR: begin
                mem_stall = 1'b1;
            end
            default: begin
                state_d = RUN;
            end
        endcase

        if (mem_stall) begin
            ctrl = CTRL_MEM_STALL;
        end else if (branch_taken) begin
            ctrl = CTRL_BRANCH;
        end else if (load_use) begin
            ctrl = CTRL_LOAD_USE;
        end

        if (!rst_n) begin
            ctrl = CTRL_NOP;
        end
    end

    assign mem_err_d = mem_err_q || (state_d == ERR);
    assign tmr_clear = (state_q == RUN) && (state_d == MEM_WAIT);
    assign tmr_inc   = (state_q == MEM_WAIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RUN;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mem_err_q <= mem_err_d;
        end
    end

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_mem_wait_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (tmr_clear),
        .inc   (tmr_inc),
        .expire(expire)
    );

    assign pc_en         = ctrl.pc_en;
    assign if_id_en      = ctrl.if_id_en;
    assign if_id_flush   = ctrl.if_id_flush;
    assign id_ex_en      = ctrl.id_ex_en;
    assign id_ex_bubble  = ctrl.id_ex_bubble;
    assign ex_mem_en     = ctrl.ex_mem_en;
    assign mem_wb_en     = ctrl.mem_wb_en;
    assign mem_wb_bubble = ctrl.mem_wb_bubble;
    assign mem_err       = mem_err_q;

`ifdef STALL_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cycles_q;
    logic [CNT_W-1:0] stall_cycles_d;
    logic [CNT_W-1:0] flush_count_q;
    logic [CNT_W-1:0] flush_count_d;

    // Saturating counters; if_id_flush outside reset means a branch flush
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        if (!ctrl.pc_en && (state_q != ERR) && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
        end
        if (ctrl.if_id_flush && (flush_count_q != '1)) begin
            flush_count_d = flush_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed self-checking bench for pipe_stall_ctrl (MEM_TIMEOUT = 4).
module tb_pipe_stall_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rt;
    logic       ex_mem_read;
    logic [4:0] ex_write_reg;
    logic       mem_req;
    logic       mem_ready;
    logic       branch_taken;
    logic       pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble;
    logic       ex_mem_en, mem_wb_en, mem_wb_bubble, mem_err;

    int tests_run = 0;
    int tests_failed = 0;

    // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_en, mem_wb_en, mem_wb_bubble}
    localparam logic [7:0] EXP_RESET = 8'b0010_1001;
    localparam logic [7:0] EXP_RUN   = 8'b1101_0110;
    localparam logic [7:0] EXP_MEMST = 8'b0000_0001;
    localparam logic [7:0] EXP_BRNCH = 8'b1111_1110;
    localparam logic [7:0] EXP_LDUSE = 8'b0001_1110;

    logic [7:0] ctl;
    assign ctl = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble,
                  ex_mem_en, mem_wb_en, mem_wb_bubble};

    always #5 clk = ~clk;

    pipe_stall_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rt   (id_uses_rt),
        .ex_mem_read  (ex_mem_read),
        .ex_write_reg (ex_write_reg),
        .mem_req      (mem_req),
        .mem_ready    (mem_ready),
        .branch_taken (branch_taken),
        .pc_en        (pc_en),
        .if_id_en     (if_id_en),
        .if_id_flush  (if_id_flush),
        .id_ex_en     (id_ex_en),
        .id_ex_bubble (id_ex_bubble),
        .ex_mem_en    (ex_mem_en),
        .mem_wb_en    (mem_wb_en),
        .mem_wb_bubble(mem_wb_bubble),
        .mem_err      (mem_err)
    );

    task automatic idle_inputs();
        id_rs = 5'd1; id_rt = 5'd2; id_uses_rt = 1'b1;
        ex_mem_read = 1'b0; ex_write_reg = 5'd3;
        mem_req = 1'b0; mem_ready = 1'b0; branch_taken = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        #1;
        tests_run++;
        if (ctl !== EXP_RESET) begin
            tests_failed++;
            $display("FAIL reset_ctl: got %b expected %b", ctl, EXP_RESET);
        end
        tests_run++;
        if (mem_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mem_err: got %b expected 0", mem_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        tests_run++;
        if (ctl !== EXP_RUN) begin
            tests_failed++;
            $display("FAIL after_reset_ctl: got %b expected %b", ctl, EXP_RUN);
        end
    endtask

    task automatic test_load_use();
        @(negedge clk);
        ex_mem_read = 1'b1; ex_write_reg = 5'd8; id_rs = 5'd8;
        #1;
        tests_run++;
        if (ctl !== EXP_LDUSE) begin
            tests_failed++;
            $display("FAIL load_use_rs: got %b expected %b", ctl, EXP_LDUSE);
        end
        @(negedge clk);
        ex_mem_read = 1'b0;
        #1;
        tests_run++;
        if (ctl !== EXP_RUN) begin
            tests_failed++;
            $display("FAIL load_use_release: got %b expected %b", ctl, EXP_RUN);
        end
        @(negedge clk);
        ex_mem_read = 1'b1; ex_write_reg = 5'd9; id_rs = 5'd4; id_rt = 5'd9; id_uses_rt = 1'b1;
        #1;
        tests_run++;
        if (ctl !== EXP_LDUSE) begin
            tests_failed++;
            $display("FAIL load_use_rt: got %b expected %b", ctl, EXP_LDUSE);
        end
        idle_inputs();
    endtask

    task automatic test_no_stall();
        @(negedge clk);
        ex_mem_read = 1'b1; ex_write_reg = 5'd0; id_rs = 5'd0;
        #1;
        tests_run++;
        if (ctl !== EXP_RUN) begin
            tests_failed++;
            $display("FAIL reg_zero: got %b expected %b", ctl, EXP_RUN);
        end
        @(negedge clk);
        ex_write_reg = 5'd9; id_rs = 5'd3; id_rt = 5'd9; id_uses_rt = 1'b0;
        #1;
        tests_run++;
        if (ctl !== EXP_RUN) begin
            tests_failed++;
            $display("FAIL rt_unused: got %b expected %b", ctl, EXP_RUN);
        end
        idle_inputs();
    endtask

    task automatic test_mem_wait();
        @(negedge clk);
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests_run++;
            if (ctl !== EXP_MEMST) begin
                tests_failed++;
                $display("FAIL mem_wait_cycle%0d: got %b expected %b", i, ctl, EXP_MEMST);
            end
            @(negedge clk);
        end
        mem_ready = 1'b1;
        #1;
        tests_run++;
        if (ctl !== EXP_RUN) begin
            tests_failed++;
            $display("FAIL mem_wait_release: got %b expected %b", ctl, EXP_RUN);
        end
        @(negedge clk);
        mem_req = 1'b0; mem_ready = 1'b0;
        #1;
        tests_run++;
        if (ctl !== EXP_RUN || mem_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL mem_wait_after: got ctl=%b err=%b expected ctl=%b err=0", ctl, mem_err, EXP_RUN);
        end
    endtask

    task automatic test_branch_load_use();
        @(negedge clk);
        branch_taken = 1'b1; ex_mem_read = 1'b1; ex_write_reg = 5'd8; id_rs = 5'd8;
        #1;
        tests_run++;
        if (ctl !== EXP_BRNCH) begin
            tests_failed++;
            $display("FAIL branch_over_load_use: got %b expected %b", ctl, EXP_BRNCH);
        end
        idle_inputs();
    endtask

    task automatic test_branch_in_wait();
        @(negedge clk);
        mem_req = 1'b1; mem_ready = 1'b0; branch_taken = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            tests_run++;
            if (ctl !== EXP_MEMST) begin
                tests_failed++;
                $display("FAIL branch_frozen%0d: got %b expected %b", i, ctl, EXP_MEMST);
            end
            @(negedge clk);
        end
        mem_ready = 1'b1;
        #1;
        tests_run++;
        if (ctl !== EXP_BRNCH) begin
            tests_failed++;
            $display("FAIL branch_at_release: got %b expected %b", ctl, EXP_BRNCH);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_timeout();
        @(negedge clk);
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            #1;
            tests_run++;
            if (ctl !== EXP_MEMST || mem_err !== 1'b0) begin
                tests_failed++;
                $display("FAIL timeout_cycle%0d: got ctl=%b err=%b expected ctl=%b err=0", i, ctl, mem_err, EXP_MEMST);
            end
            @(negedge clk);
        end
        #1;
        tests_run++;
        if (ctl !== EXP_MEMST || mem_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL timeout_err_set: got ctl=%b err=%b expected ctl=%b err=1", ctl, mem_err, EXP_MEMST);
        end
        @(negedge clk);
        mem_ready = 1'b1; branch_taken = 1'b1;
        #1;
        tests_run++;
        if (ctl !== EXP_MEMST || mem_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL err_sticky_ready: got ctl=%b err=%b expected ctl=%b err=1", ctl, mem_err, EXP_MEMST);
        end
        @(negedge clk);
        #1;
        tests_run++;
        if (ctl !== EXP_MEMST || mem_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL err_sticky_hold: got ctl=%b err=%b expected ctl=%b err=1", ctl, mem_err, EXP_MEMST);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (ctl !== EXP_RESET || mem_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL err_reset: got ctl=%b err=%b expected ctl=%b err=0", ctl, mem_err, EXP_RESET);
        end
        @(negedge clk);
        rst_n = 1'b1;
        idle_inputs();
        mem_req = 1'b1; mem_ready = 1'b1;
        #1;
        tests_run++;
        if (ctl !== EXP_RUN || mem_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL run_after_err_reset: got ctl=%b err=%b expected ctl=%b err=0", ctl, mem_err, EXP_RUN);
        end
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        tests_run++;
        if (ctl !== EXP_MEMST) begin
            tests_failed++;
            $display("FAIL stall_after_err_reset: got %b expected %b", ctl, EXP_MEMST);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_load_use();
        test_no_stall();
        test_mem_wait();
        test_branch_load_use();
        test_branch_in_wait();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
